// File: rtl/fir_param_pkg.sv
// Shared constants, FSM encoding and saturation helpers for fir_param.
package fir_param_pkg;

    // AXI-Lite register offsets
    localparam int unsigned ADDR_CTRL    = 32'h00;
    localparam int unsigned ADDR_LEN     = 32'h10;
    localparam int unsigned ADDR_TAPN    = 32'h14;
    localparam int unsigned ADDR_SHIFT   = 32'h18;
    localparam int unsigned ADDR_COEF    = 32'h20;
    // Region frozen while a frame is running
    localparam int unsigned ADDR_BUSY_LO = 32'h10;
    localparam int unsigned ADDR_BUSY_HI = 32'h7F;

    // ap_ctrl bit indices
    localparam int unsigned CTRL_START     = 0;
    localparam int unsigned CTRL_DONE      = 1;
    localparam int unsigned CTRL_IDLE      = 2;
    localparam int unsigned CTRL_TLAST_ERR = 5;

    // Width used for shift/saturate arithmetic; must cover the accumulator
    localparam int unsigned SAT_W = 128;

    typedef enum logic [1:0] {StIdle, StWaitIn, StMac, StOut} state_e;

    // Largest value representable in a signed w-bit word
    function automatic logic signed [SAT_W-1:0] sat_max(input int unsigned w);
        logic signed [SAT_W-1:0] one;
        one = {{(SAT_W-1){1'b0}}, 1'b1};
        return (one <<< (w - 1)) - one;
    endfunction

    // Smallest value representable in a signed w-bit word
    function automatic logic signed [SAT_W-1:0] sat_min(input int unsigned w);
        logic signed [SAT_W-1:0] one;
        one = {{(SAT_W-1){1'b0}}, 1'b1};
        return {SAT_W{1'b0}} - (one <<< (w - 1));
    endfunction

endpackage

// File: rtl/fir_param_axil.sv
// AXI-Lite slave: register file, coefficient array and ap_ctrl side effects.
module fir_param_axil
    import fir_param_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned pTAP_MAX    = 16,
    parameter int unsigned TAPW        = $clog2(pTAP_MAX + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 awvalid,
    output logic                                 awready,
    input  logic [pADDR_WIDTH-1:0]               awaddr,
    input  logic                                 wvalid,
    output logic                                 wready,
    input  logic [pDATA_WIDTH-1:0]               wdata,
    input  logic                                 arvalid,
    output logic                                 arready,
    input  logic [pADDR_WIDTH-1:0]               araddr,
    output logic                                 rvalid,
    input  logic                                 rready,
    output logic [pDATA_WIDTH-1:0]               rdata,
    input  logic                                 done_set,
    input  logic                                 tlast_err_set,
    output logic                                 start,
    output logic [pDATA_WIDTH-1:0]               data_length,
    output logic [TAPW-1:0]                      tap_num,
    output logic [4:0]                           out_shift,
    output logic [pTAP_MAX-1:0][pDATA_WIDTH-1:0] coef
);

    logic                                 aw_ready_q, ar_ready_q, rvalid_q;
    logic [pDATA_WIDTH-1:0]               rdata_q, rd_val;
    logic                                 ap_start_q, ap_done_q, ap_idle_q, tlast_err_q;
    logic [pDATA_WIDTH-1:0]               data_length_q;
    logic [TAPW-1:0]                      tap_num_q, tap_clamp;
    logic [4:0]                           out_shift_q;
    logic [pTAP_MAX-1:0][pDATA_WIDTH-1:0] coef_q;
    logic                                 wr_fire, rd_fire, wr_allowed;

    assign awready     = aw_ready_q;
    assign wready      = aw_ready_q;
    assign arready     = ar_ready_q;
    assign rvalid      = rvalid_q;
    assign rdata       = rdata_q;
    assign data_length = data_length_q;
    assign tap_num     = tap_num_q;
    assign out_shift   = out_shift_q;
    assign coef        = coef_q;

    assign wr_fire    = aw_ready_q && awvalid && wvalid;
    assign rd_fire    = ar_ready_q && arvalid;
    assign wr_allowed = ap_idle_q || !((awaddr >= pADDR_WIDTH'(ADDR_BUSY_LO)) &&
                                       (awaddr <= pADDR_WIDTH'(ADDR_BUSY_HI)));
    assign start      = wr_fire && (awaddr == pADDR_WIDTH'(ADDR_CTRL)) &&
                        wdata[CTRL_START] && ap_idle_q;

    // Clamp a tap_num write into 1..pTAP_MAX
    always_comb begin
        if (wdata == '0) begin
            tap_clamp = TAPW'(1);
        end else if (wdata > pDATA_WIDTH'(pTAP_MAX)) begin
            tap_clamp = TAPW'(pTAP_MAX);
        end else begin
            tap_clamp = TAPW'(wdata);
        end
    end

    // Read data mux; unmapped addresses read as zero
    always_comb begin
        rd_val = '0;
        if (araddr == pADDR_WIDTH'(ADDR_CTRL)) begin
            rd_val[CTRL_START]     = ap_start_q;
            rd_val[CTRL_DONE]      = ap_done_q;
            rd_val[CTRL_IDLE]      = ap_idle_q;
            rd_val[CTRL_TLAST_ERR] = tlast_err_q;
        end else if (araddr == pADDR_WIDTH'(ADDR_LEN)) begin
            rd_val = data_length_q;
        end else if (araddr == pADDR_WIDTH'(ADDR_TAPN)) begin
            rd_val = pDATA_WIDTH'(tap_num_q);
        end else if (araddr == pADDR_WIDTH'(ADDR_SHIFT)) begin
            rd_val = pDATA_WIDTH'(out_shift_q);
        end
        for (int k = 0; k < pTAP_MAX; k++) begin
            if (araddr == pADDR_WIDTH'(ADDR_COEF + 4 * k)) rd_val = coef_q[k];
        end
    end

    // Handshakes: one-cycle ready pulses, single outstanding read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_ready_q <= 1'b0;
            ar_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            aw_ready_q <= awvalid && wvalid && !aw_ready_q;
            ar_ready_q <= arvalid && !rvalid_q && !ar_ready_q;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
            end else if (rvalid_q && rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Configuration registers, frozen while a frame runs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_length_q <= '0;
            tap_num_q     <= TAPW'(pTAP_MAX);
            out_shift_q   <= '0;
            coef_q        <= '0;
        end else if (wr_fire && wr_allowed) begin
            if (awaddr == pADDR_WIDTH'(ADDR_LEN))   data_length_q <= wdata;
            if (awaddr == pADDR_WIDTH'(ADDR_TAPN))  tap_num_q     <= tap_clamp;
            if (awaddr == pADDR_WIDTH'(ADDR_SHIFT)) out_shift_q   <= wdata[4:0];
            for (int k = 0; k < pTAP_MAX; k++) begin
                if (awaddr == pADDR_WIDTH'(ADDR_COEF + 4 * k)) coef_q[k] <= wdata;
            end
        end
    end

    // ap_ctrl status bits; a frame finishing wins over a clear-on-read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ap_start_q  <= 1'b0;
            ap_done_q   <= 1'b0;
            ap_idle_q   <= 1'b1;
            tlast_err_q <= 1'b0;
        end else begin
            ap_start_q <= start;
            if (start) begin
                ap_done_q   <= 1'b0;
                ap_idle_q   <= 1'b0;
                tlast_err_q <= 1'b0;
            end else begin
                if (done_set) begin
                    ap_done_q <= 1'b1;
                    ap_idle_q <= 1'b1;
                end else if (rd_fire && (araddr == pADDR_WIDTH'(ADDR_CTRL))) begin
                    ap_done_q <= 1'b0;
                end
                if (tlast_err_set) tlast_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_param.sv
// Runtime-programmable FIR: frame FSM, sample history and serial MAC datapath.
module fir_param
    import fir_param_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned pTAP_MAX    = 16,
    parameter int unsigned pACC_WIDTH  = 72
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   ss_tvalid,
    output logic                   ss_tready,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast
);

    localparam int unsigned TAPW = $clog2(pTAP_MAX + 1);
    localparam int unsigned KW   = (pTAP_MAX > 1) ? $clog2(pTAP_MAX) : 1;
    localparam int unsigned PW   = 2 * pDATA_WIDTH;

    logic                                 start, done_set, tlast_err_set;
    logic [pDATA_WIDTH-1:0]               data_length;
    logic [TAPW-1:0]                      tap_num;
    logic [4:0]                           out_shift;
    logic [pTAP_MAX-1:0][pDATA_WIDTH-1:0] coef;

    state_e                               state_q, state_d;
    logic [pTAP_MAX-1:0][pDATA_WIDTH-1:0] hist_q;
    logic [KW-1:0]                        k_q;
    logic signed [pACC_WIDTH-1:0]         acc_q, acc_next;
    logic [pDATA_WIDTH-1:0]               out_cnt_q, out_data_q, sat_res;
    logic                                 out_last_q, is_last, mac_last;
    logic signed [PW-1:0]                 prod;
    logic signed [SAT_W-1:0]              acc_wide, acc_shr;

    fir_param_axil #(
        .pADDR_WIDTH(pADDR_WIDTH),
        .pDATA_WIDTH(pDATA_WIDTH),
        .pTAP_MAX   (pTAP_MAX),
        .TAPW       (TAPW)
    ) u_axil (
        .clk          (axis_clk),
        .rst          (axis_rst),
        .awvalid      (awvalid),
        .awready      (awready),
        .awaddr       (awaddr),
        .wvalid       (wvalid),
        .wready       (wready),
        .wdata        (wdata),
        .arvalid      (arvalid),
        .arready      (arready),
        .araddr       (araddr),
        .rvalid       (rvalid),
        .rready       (rready),
        .rdata        (rdata),
        .done_set     (done_set),
        .tlast_err_set(tlast_err_set),
        .start        (start),
        .data_length  (data_length),
        .tap_num      (tap_num),
        .out_shift    (out_shift),
        .coef         (coef)
    );

    assign is_last  = out_cnt_q == (data_length - pDATA_WIDTH'(1));
    assign mac_last = (32'(k_q) + 32'd1) == 32'(tap_num);
    assign sm_tdata = out_data_q;
    assign sm_tlast = out_last_q;

    // Full-precision signed MAC step, then arithmetic shift and saturation of its result
    always_comb begin
        prod     = $signed(coef[k_q]) * $signed(hist_q[k_q]);
        acc_next = acc_q + {{(pACC_WIDTH-PW){prod[PW-1]}}, prod};
        acc_wide = {{(SAT_W-pACC_WIDTH){acc_next[pACC_WIDTH-1]}}, acc_next};
        acc_shr  = acc_wide >>> out_shift;
        if (acc_shr > sat_max(pDATA_WIDTH)) begin
            sat_res = pDATA_WIDTH'(sat_max(pDATA_WIDTH));
        end else if (acc_shr < sat_min(pDATA_WIDTH)) begin
            sat_res = pDATA_WIDTH'(sat_min(pDATA_WIDTH));
        end else begin
            sat_res = pDATA_WIDTH'(acc_shr);
        end
    end

    // Frame FSM next state and stream handshake outputs
    always_comb begin
        state_d       = state_q;
        done_set      = 1'b0;
        tlast_err_set = 1'b0;
        ss_tready     = 1'b0;
        sm_tvalid     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StWaitIn;
            end
            StWaitIn: begin
                // An empty frame finishes without touching the stream
                if (data_length == '0) begin
                    done_set = 1'b1;
                    state_d  = StIdle;
                end else begin
                    ss_tready = 1'b1;
                    if (ss_tvalid) begin
                        tlast_err_set = ss_tlast != is_last;
                        state_d       = StMac;
                    end
                end
            end
            StMac: begin
                if (mac_last) state_d = StOut;
            end
            StOut: begin
                sm_tvalid = 1'b1;
                if (sm_tready) begin
                    if (out_last_q) begin
                        done_set = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        state_d = StWaitIn;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state register
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // History shift register, MAC accumulator and registered output word
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            hist_q     <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            out_cnt_q  <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        hist_q    <= '0;
                        out_cnt_q <= '0;
                    end
                end
                StWaitIn: begin
                    if (ss_tready && ss_tvalid) begin
                        for (int i = pTAP_MAX - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
                        hist_q[0] <= ss_tdata;
                        k_q       <= '0;
                        acc_q     <= '0;
                    end
                end
                StMac: begin
                    acc_q <= acc_next;
                    k_q   <= k_q + KW'(1);
                    if (mac_last) begin
                        out_data_q <= sat_res;
                        out_last_q <= is_last;
                    end
                end
                StOut: begin
                    if (sm_tready) out_cnt_q <= out_cnt_q + pDATA_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_param.sv
// Randomised scoreboard bench for fir_param with a convolution reference model.
module tb_fir_param;

    localparam int TM = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic        ss_tvalid, ss_tready, ss_tlast, sm_tvalid, sm_tready, sm_tlast;
    logic [31:0] ss_tdata, sm_tdata;

    always #5 clk = ~clk;

    fir_param #(
        .pADDR_WIDTH(12),
        .pDATA_WIDTH(32),
        .pTAP_MAX   (TM),
        .pACC_WIDTH (72)
    ) dut (
        .axis_clk (clk),
        .axis_rst (rst),
        .awvalid  (awvalid),
        .awready  (awready),
        .awaddr   (awaddr),
        .wvalid   (wvalid),
        .wready   (wready),
        .wdata    (wdata),
        .arvalid  (arvalid),
        .arready  (arready),
        .araddr   (araddr),
        .rvalid   (rvalid),
        .rready   (rready),
        .rdata    (rdata),
        .ss_tvalid(ss_tvalid),
        .ss_tready(ss_tready),
        .ss_tdata (ss_tdata),
        .ss_tlast (ss_tlast),
        .sm_tvalid(sm_tvalid),
        .sm_tready(sm_tready),
        .sm_tdata (sm_tdata),
        .sm_tlast (sm_tlast)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    int                checks = 0;
    int                errors = 0;
    exp_t              exp_q[$];
    logic signed [31:0] m_coef[TM];
    logic signed [31:0] m_xs[$];
    int                m_tap, m_shift, m_len;
    int                bp_mode = 0;
    int                out_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // y[n] = sat((sum_k c[k]*x[n-k]) >>> shift), x before frame start is zero
    function automatic logic [31:0] model_y();
        logic signed [127:0] acc, c, x;
        int n;
        acc = 0;
        n   = m_xs.size() - 1;
        for (int k = 0; k < m_tap; k++) begin
            if (n - k >= 0) begin
                c   = m_coef[k];
                x   = m_xs[n-k];
                acc = acc + c * x;
            end
        end
        acc = acc >>> m_shift;
        if (acc > 128'sh7FFFFFFF) acc = 128'sh7FFFFFFF;
        if (acc < -128'sh80000000) acc = -128'sh80000000;
        return acc[31:0];
    endfunction

    task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
        int n;
        @(posedge clk); #1;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (awready) break;
            n++;
            if (n > 100) begin timeout_fail("awready"); break; end
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axil_read(input logic [11:0] a, output logic [31:0] d);
        int n;
        @(posedge clk); #1;
        arvalid = 1'b1; araddr = a;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (arready) break;
            n++;
            if (n > 100) begin timeout_fail("arready"); break; end
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 100) begin @(negedge clk); n++; end
        if (!rvalid) timeout_fail("rvalid");
        d = rdata;
        @(negedge clk);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic check_read(input string name, input logic [11:0] a, input logic [31:0] expv);
        logic [31:0] d;
        axil_read(a, d);
        chk(name, 64'(d), 64'(expv));
    endtask

    // Program the DUT from the model's config (coefs taken from m_coef)
    task automatic configure(input int tap, input int shift, input int len);
        axil_write(12'h014, tap);
        m_tap = (tap < 1) ? 1 : ((tap > TM) ? TM : tap);
        axil_write(12'h018, shift);
        m_shift = shift & 31;
        axil_write(12'h010, len);
        m_len = len;
        for (int k = 0; k < TM; k++) axil_write(12'(32'h20 + 4 * k), m_coef[k]);
    endtask

    task automatic start_frame();
        axil_write(12'h000, 32'h1);
        m_xs.delete();
    endtask

    // Queue the expected response, then offer the sample on the slave stream
    task automatic send(input logic [31:0] x, input logic last);
        exp_t e;
        int   n;
        m_xs.push_back(x);
        e.data = model_y();
        e.last = (m_xs.size() == m_len);
        exp_q.push_back(e);
        @(posedge clk); #1;
        ss_tvalid = 1'b1; ss_tdata = x; ss_tlast = last;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (ss_tready) break;
            n++;
            if (n > 2000) begin timeout_fail("ss_tready"); break; end
        end
        @(posedge clk); #1;
        ss_tvalid = 1'b0; ss_tlast = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) timeout_fail("drain");
        repeat (3) @(posedge clk);
    endtask

    task automatic set_coefs_1234();
        for (int k = 0; k < TM; k++) m_coef[k] = (k < 4) ? 32'(k + 1) : 32'(k * 7 + 100);
    endtask

    task automatic run_1to5(input int shift);
        set_coefs_1234();
        configure(4, shift, 5);
        start_frame();
        for (int i = 1; i <= 5; i++) send(32'(i), i == 5);
        drain();
        check_read("ctrl_after_1to5", 12'h000, 32'h6);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_sm_tvalid"}, 64'(sm_tvalid), 64'd0);
        chk({tag, "_sm_tdata"}, 64'(sm_tdata), 64'd0);
        chk({tag, "_sm_tlast"}, 64'(sm_tlast), 64'd0);
        chk({tag, "_ss_tready"}, 64'(ss_tready), 64'd0);
        chk({tag, "_awready"}, 64'(awready), 64'd0);
        chk({tag, "_arready"}, 64'(arready), 64'd0);
        chk({tag, "_rvalid"}, 64'(rvalid), 64'd0);
        chk({tag, "_rdata"}, 64'(rdata), 64'd0);
    endtask

    // Monitor: drives sm_tready, checks stall stability and pops the scoreboard
    initial begin
        int          stall, target;
        logic [31:0] held_d;
        logic        held_l;
        exp_t        e;
        stall = 0; target = 0; held_d = '0; held_l = 1'b0;
        sm_tready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 0;
                sm_tready = 1'b0;
            end else if (sm_tvalid) begin
                chk("ss_tready_while_out", 64'(ss_tready), 64'd0);
                if (stall == 0) begin
                    held_d = sm_tdata;
                    held_l = sm_tlast;
                    target = (bp_mode == 1) ? 7 : ((bp_mode == 2) ? int'($urandom_range(0, 3)) : 0);
                end else begin
                    chk("stall_tdata_stable", 64'(sm_tdata), 64'(held_d));
                    chk("stall_tlast_stable", 64'(sm_tlast), 64'(held_l));
                end
                if (stall < target) begin
                    sm_tready = 1'b0;
                    stall++;
                end else begin
                    sm_tready = 1'b1;
                    stall = 0;
                    out_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %0h expected none", sm_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sm_tdata", 64'(sm_tdata), 64'(e.data));
                        chk("sm_tlast", 64'(sm_tlast), 64'(e.last));
                    end
                end
            end else begin
                sm_tready = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, n;
        rst = 1'b1;
        awvalid = 0; wvalid = 0; arvalid = 0; rready = 0; ss_tvalid = 0; ss_tlast = 0;
        awaddr = '0; araddr = '0; wdata = '0; ss_tdata = '0;
        for (int k = 0; k < TM; k++) m_coef[k] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset register values and register map edges
        check_read("ctrl_reset", 12'h000, 32'h4);
        check_read("tapn_reset", 12'h014, 32'd16);
        check_read("len_reset", 12'h010, 32'd0);
        check_read("coef0_reset", 12'h020, 32'd0);
        axil_write(12'h014, 0);
        check_read("tapn_clamp_lo", 12'h014, 32'd1);
        axil_write(12'h014, 100);
        check_read("tapn_clamp_hi", 12'h014, 32'd16);
        axil_write(12'h018, 32'hFF);
        check_read("shift_mask", 12'h018, 32'h1F);
        axil_write(12'h00C, 32'hDEAD);
        check_read("unmapped", 12'h00C, 32'd0);

        // Variable taps, then with shift and heavy backpressure
        run_1to5(0);
        bp_mode = 1;
        run_1to5(1);
        bp_mode = 0;

        // Saturation in both directions; unused upper coefs must not contribute
        for (int k = 0; k < TM; k++) m_coef[k] = $urandom;
        m_coef[0] = 32'd2;
        configure(1, 0, 2);
        start_frame();
        send(32'h40000000, 1'b0);
        send(32'hA0000000, 1'b1);
        drain();

        // Busy protection and tlast mismatch
        set_coefs_1234();
        configure(4, 0, 5);
        start_frame();
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        axil_write(12'h020, 32'd99);
        axil_write(12'h010, 32'd2);
        axil_write(12'h000, 32'h1);
        check_read("coef0_busy", 12'h020, 32'd1);
        send(32'd3, 1'b1);
        send(32'd4, 1'b0);
        send(32'd5, 1'b1);
        drain();
        check_read("ctrl_tlast_err", 12'h000, 32'h26);
        check_read("ctrl_done_cleared", 12'h000, 32'h24);

        // Empty frame: done immediately, no stream traffic, error cleared
        axil_write(12'h010, 32'd0);
        axil_write(12'h000, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("len0_ss_tready", 64'(ss_tready), 64'd0);
        end
        check_read("ctrl_len0", 12'h000, 32'h6);

        // Reset in the middle of a frame
        set_coefs_1234();
        configure(4, 0, 10);
        start_frame();
        base = out_seen;
        for (int i = 1; i <= 3; i++) send(32'(i), 1'b0);
        n = 0;
        while (out_seen < base + 3 && n < 200) begin @(negedge clk); n++; end
        if (out_seen < base + 3) timeout_fail("three_outputs");
        send(32'd4, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        m_xs.delete();
        for (int k = 0; k < TM; k++) m_coef[k] = '0;
        @(negedge clk);
        check_outputs_zero("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        check_read("ctrl_midreset", 12'h000, 32'h4);
        check_read("coef1_midreset", 12'h024, 32'd0);
        check_read("tapn_midreset", 12'h014, 32'd16);
        run_1to5(0);

        // Randomised frames with random or long backpressure
        for (int f = 0; f < 4; f++) begin
            int tap, shift, len;
            for (int k = 0; k < TM; k++) begin
                int v;
                v = int'($urandom_range(0, 2000)) - 1000;
                m_coef[k] = (f % 2 == 0) ? 32'($urandom) : 32'(v);
            end
            tap   = int'($urandom_range(1, TM));
            shift = (f % 2 == 0) ? int'($urandom_range(20, 31)) : int'($urandom_range(0, 4));
            len   = int'($urandom_range(6, 14));
            bp_mode = (f == 1) ? 1 : 2;
            configure(tap, shift, len);
            start_frame();
            for (int i = 0; i < len; i++) send($urandom, i == len - 1);
            drain();
            check_read("ctrl_random", 12'h000, 32'h6);
        end
        bp_mode = 0;

        // Triangular-wave regression, 11 taps, 600 samples
        for (int k = 0; k < TM; k++) m_coef[k] = '0;
        m_coef[1] = -32'sd10; m_coef[2] = -32'sd9; m_coef[3] = 32'sd23; m_coef[4] = 32'sd56;
        m_coef[5] = 32'sd63;  m_coef[6] = 32'sd56; m_coef[7] = 32'sd23; m_coef[8] = -32'sd9;
        m_coef[9] = -32'sd10;
        configure(11, 0, 600);
        start_frame();
        for (int i = 0; i < 600; i++) begin
            int t, x;
            t = i % 64;
            x = ((t < 32) ? t : 64 - t) * 1000 - 16000;
            send(32'(x), i == 599);
        end
        drain();
        check_read("ctrl_triangle", 12'h000, 32'h6);
        check_read("ctrl_triangle_reread", 12'h000, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
